seq_mult_32: RTL and testbench

//  Multi-cycle shift-add multiplier, 32x32 -> 64-bit product, unsigned or signed.

---
 rtl/seq_mult_32_pkg.sv | 22 ++
 rtl/seq_mult_32_if.sv | 24 ++
 rtl/rca_32bit.sv | 26 ++
 rtl/seq_mult_32.sv | 131 +++++++++++++
 tb/tb_seq_mult_32.sv | 117 +++++++++++
 5 files changed

// File: rtl/seq_mult_32_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mult_32_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Magnitude of a two's-complement operand; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

endpackage

// File: rtl/seq_mult_32_if.sv
// Operand/result handshake bundle between the issue stage, the multiplier and writeback.
interface seq_mult_32_if;
  import seq_mult_32_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     operand_a;
  logic [WIDTH-1:0]     operand_b;
  logic                 signed_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output in_valid, operand_a, operand_b, signed_mode, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, operand_a, operand_b, signed_mode, out_ready,
    output in_ready, out_valid, product
  );

endinterface

// File: rtl/rca_32bit.sv
// 32-bit ripple-carry adder/subtractor; subtract_mode inverts b and forces the carry in.
module rca_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carry_in,
  input  logic        subtract_mode,
  output logic [31:0] sum,
  output logic        carry_out,
  output logic        overflow
);

  logic [32:0] carry_s;
  logic [31:0] b_eff_s;

  assign carry_s[0] = carry_in | subtract_mode;

  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign b_eff_s[i]     = b[i] ^ subtract_mode;
    assign sum[i]         = a[i] ^ b_eff_s[i] ^ carry_s[i];
    assign carry_s[i + 1] = (a[i] & b_eff_s[i]) | (carry_s[i] & (a[i] ^ b_eff_s[i]));
  end

  assign carry_out = carry_s[32];
  assign overflow  = carry_s[32] ^ carry_s[31];

endmodule

// File: rtl/seq_mult_32.sv
// 32x32 -> 64 shift-add multiplier, one partial-product add per cycle, valid/ready on both sides.
module seq_mult_32 #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_mult_32_if.slave  bus
);
  import seq_mult_32_pkg::*;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic                neg_q, neg_d;
  logic [2*WIDTH-1:0]  product_q, product_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  logic                is_signed_s;
  logic [WIDTH-1:0]    addend_s;
  logic [WIDTH-1:0]    add_sum_s;
  logic                add_cout_s;
  logic                unused_ovf_s;

  assign is_signed_s = bus.signed_mode & SIGNED_EN;
  assign addend_s    = {WIDTH{mplier_q[0]}} & mcand_q;

  rca_32bit u_rca (
    .a             (acc_hi_q),
    .b             (addend_s),
    .carry_in      (1'b0),
    .subtract_mode (1'b0),
    .sum           (add_sum_s),
    .carry_out     (add_cout_s),
    .overflow      (unused_ovf_s)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_hi_d    = acc_hi_q;
    mplier_d    = mplier_q;
    mcand_d     = mcand_q;
    neg_d       = neg_q;
    product_d   = product_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (bus.in_valid && in_ready_q) begin
          mcand_d    = is_signed_s ? mag32(bus.operand_a) : bus.operand_a;
          mplier_d   = is_signed_s ? mag32(bus.operand_b) : bus.operand_b;
          neg_d      = is_signed_s & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
          acc_hi_d   = {WIDTH{1'b0}};
          count_d    = {CNT_W{1'b0}};
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      // 65-bit right shift of {carry, sum, multiplier}; the LSB of sum becomes a product bit.
      ST_RUN: begin
        acc_hi_d = {add_cout_s, add_sum_s[WIDTH-1:1]};
        mplier_d = {add_sum_s[0], mplier_q[WIDTH-1:1]};
        count_d  = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end

      // First DONE cycle applies the sign and publishes; afterwards product holds until taken.
      ST_DONE: begin
        if (!out_valid_q) begin
          product_d   = neg_q ? neg64({acc_hi_q, mplier_q}) : {acc_hi_q, mplier_q};
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= {CNT_W{1'b0}};
      acc_hi_q    <= {WIDTH{1'b0}};
      mplier_q    <= {WIDTH{1'b0}};
      mcand_q     <= {WIDTH{1'b0}};
      neg_q       <= 1'b0;
      product_q   <= {(2*WIDTH){1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_hi_q    <= acc_hi_d;
      mplier_q    <= mplier_d;
      mcand_q     <= mcand_d;
      neg_q       <= neg_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;

endmodule

// File: tb/tb_seq_mult_32.sv
// Directed bench: two multipliers (signed-capable and SIGNED_EN=0) driven with identical stimulus.
module tb_seq_mult_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        signed_mode;
  logic        out_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  int          checks = 0;
  int          errors = 0;

  seq_mult_32_if bus_s ();
  seq_mult_32_if bus_u ();

  assign bus_s.in_valid    = in_valid;
  assign bus_s.operand_a   = op_a;
  assign bus_s.operand_b   = op_b;
  assign bus_s.signed_mode = signed_mode;
  assign bus_s.out_ready   = out_ready;
  assign bus_u.in_valid    = in_valid;
  assign bus_u.operand_a   = op_a;
  assign bus_u.operand_b   = op_b;
  assign bus_u.signed_mode = signed_mode;
  assign bus_u.out_ready   = out_ready;

  seq_mult_32 #(.WIDTH(32), .SIGNED_EN(1'b1)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));
  seq_mult_32 #(.WIDTH(32), .SIGNED_EN(1'b0)) u_dut_u (.clk(clk), .rst_n(rst_n), .bus(bus_u));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Issue one operation, optionally stall the result for hold cycles, then retire it.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sm, input logic early_ready, input int hold,
                        input logic [63:0] exp_s, input logic [63:0] exp_u);
    int lat;
    lat = 0;
    while (!bus_s.in_ready && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_idle"}, {63'd0, bus_s.in_ready}, 64'd1);
    op_a = a; op_b = b; signed_mode = sm; in_valid = 1'b1; out_ready = early_ready;
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = 32'hDEADBEEF; op_b = 32'h13579BDF; signed_mode = ~sm;
    check({tag, "_busy"}, {63'd0, bus_s.in_ready}, 64'd0);
    lat = 0;
    while (!bus_s.out_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd33);
    check({tag, "_prod_s"}, bus_s.product, exp_s);
    check({tag, "_prod_u"}, bus_u.product, exp_u);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op_a = 32'd9; op_b = 32'd9;
      @(posedge clk); #1;
      check({tag, "_hold_v"}, {62'd0, bus_s.out_valid, bus_s.in_ready}, 64'd2);
      check({tag, "_hold_p"}, bus_s.product, exp_s);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_retire"}, {62'd0, bus_s.out_valid, bus_s.in_ready}, 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; signed_mode = 1'b0; out_ready = 1'b0;
    op_a = 32'd0; op_b = 32'd0;
    #12;
    check("rst_prod", bus_s.product, 64'd0);
    check("rst_flags", {62'd0, bus_s.out_valid, bus_s.in_ready}, 64'd1);
    @(negedge clk); rst_n = 1'b1;

    run_op("u3x5",   32'd3,        32'd5,        1'b0, 1'b0, 0, 64'h000000000000000F, 64'h000000000000000F);
    run_op("umax",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 0, 64'hFFFFFFFE00000001, 64'hFFFFFFFE00000001);
    run_op("sm3x7",  32'hFFFFFFFD, 32'h00000007, 1'b1, 1'b0, 0, 64'hFFFFFFFFFFFFFFEB, 64'h00000006FFFFFFEB);
    run_op("smin",   32'h80000000, 32'h80000000, 1'b1, 1'b0, 0, 64'h4000000000000000, 64'h4000000000000000);
    run_op("sm1m1",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 0, 64'h0000000000000001, 64'hFFFFFFFE00000001);
    run_op("s5m1",   32'd5,        32'hFFFFFFFF, 1'b1, 1'b0, 0, 64'hFFFFFFFFFFFFFFFB, 64'h00000004FFFFFFFB);
    run_op("stall",  32'd6,        32'd7,        1'b0, 1'b0, 5, 64'h000000000000002A, 64'h000000000000002A);

    // Reset in the middle of RUN: state must collapse at once, no partial product.
    op_a = 32'd100; op_b = 32'd100; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_flags", {62'd0, bus_s.out_valid, bus_s.in_ready}, 64'd1);
    check("mid_rst_prod", bus_s.product, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("post2x2", 32'd2, 32'd2, 1'b0, 1'b0, 0, 64'd4, 64'd4);

    run_op("mneg2",  32'hFFFFFFFF, 32'd2,        1'b1, 1'b0, 0, 64'hFFFFFFFFFFFFFFFE, 64'h00000001FFFFFFFE);
    run_op("zero_a", 32'd0,        32'hFFFFFFFF, 1'b1, 1'b1, 0, 64'd0, 64'd0);
    run_op("zero_b", 32'h12345678, 32'd0,        1'b0, 1'b1, 0, 64'd0, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
